// File: rtl/psum_addr_ctrl.sv
// Partial-sum scratchpad sequencer: read-modify-write sweeps over num_psums addresses for
// num_passes passes, with a MAC_LAT-deep write-back pipe and read-after-write interlock.
module psum_addr_ctrl #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned PASS_WIDTH = 8,
    parameter int unsigned MAC_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] num_psums_i,
    input  logic [PASS_WIDTH-1:0] num_passes_i,
    input  logic                  stall_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  rd_first_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic                  wr_last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   n_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [PASS_WIDTH-1:0]   p_q;
    logic [PASS_WIDTH-1:0]   pass_q;
    logic [MAC_LAT-1:0]      pv_q;
    logic [MAC_LAT-1:0]      pl_q;
    logic [ADDR_WIDTH-1:0]   pa_q [MAC_LAT];

    logic hazard;
    logic rd_fire;
    logic last_addr;
    logic last_pass;
    logic pipe_tail_busy;

    always_comb begin
        hazard = 1'b0;
        // Only short sweeps can revisit an address still in flight.
        if (32'(n_q) <= MAC_LAT) begin
            for (int i = 0; i < int'(MAC_LAT); i++) begin
                if (pv_q[i] && (pa_q[i] == addr_q)) hazard = 1'b1;
            end
        end
    end

    always_comb begin
        pipe_tail_busy = 1'b0;
        for (int i = 0; i < int'(MAC_LAT) - 1; i++) begin
            pipe_tail_busy = pipe_tail_busy | pv_q[i];
        end
    end

    assign rd_fire   = (state_q == StRun) && !stall_i && !hazard;
    assign last_addr = (addr_q == n_q - ADDR_WIDTH'(1));
    assign last_pass = (pass_q == p_q - PASS_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            n_q     <= '0;
            p_q     <= '0;
            addr_q  <= '0;
            pass_q  <= '0;
            pv_q    <= '0;
            pl_q    <= '0;
            for (int i = 0; i < int'(MAC_LAT); i++) pa_q[i] <= '0;
        end else begin
            if (!stall_i) begin
                pv_q[0] <= rd_fire;
                pa_q[0] <= addr_q;
                pl_q[0] <= last_pass;
                for (int i = 1; i < int'(MAC_LAT); i++) begin
                    pv_q[i] <= pv_q[i-1];
                    pa_q[i] <= pa_q[i-1];
                    pl_q[i] <= pl_q[i-1];
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        n_q    <= num_psums_i;
                        p_q    <= num_passes_i;
                        addr_q <= '0;
                        pass_q <= '0;
                        state_q <= (num_psums_i != '0 && num_passes_i != '0) ? StRun : StDone;
                    end
                end
                StRun: begin
                    if (rd_fire) begin
                        if (last_addr) begin
                            addr_q <= '0;
                            if (last_pass) begin
                                pass_q  <= '0;
                                state_q <= StDrain;
                            end else begin
                                pass_q <= pass_q + PASS_WIDTH'(1);
                            end
                        end else begin
                            addr_q <= addr_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                // The final write retires this cycle when only the output stage is occupied.
                StDrain: if (!stall_i && !pipe_tail_busy) state_q <= StDone;
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rd_en_o    = rd_fire;
    assign rd_addr_o  = addr_q;
    assign rd_first_o = rd_fire && (pass_q == '0);
    assign wr_en_o    = pv_q[MAC_LAT-1] && !stall_i;
    assign wr_addr_o  = pa_q[MAC_LAT-1];
    assign wr_last_o  = wr_en_o && pl_q[MAC_LAT-1];
    assign busy_o     = (state_q == StRun) || (state_q == StDrain);
    assign done_o     = (state_q == StDone);

endmodule
